if_stage: RTL

- Instruction-fetch stage and IF/ID pipeline register of the 5-stage PoliRISC-V core.
- Directly upstream of decode. It consumes the hazard unit's stall_if, stall_id and flush_id, plus the redirect from execute or the trap logic.
- Owns the PC and the instruction-memory read handshake.
- Buffers one returned instruction when decode is stalled, and discards in-flight fetches on a redirect.

---
 rtl/if_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the PoliRISC-V core.
// It owns the PC, the instruction-memory read handshake and a one-entry hold buffer.
//
// state | meaning
// IDLE  | no request outstanding, waiting for stall_if to drop
// REQ   | request outstanding, returned data is accepted
// DROP  | request outstanding, returned data is discarded because a redirect occurred
// HOLD  | one returned instruction is parked until decode frees up
module if_stage #(
  parameter int                   DATA_SIZE = 32,
  parameter logic [DATA_SIZE-1:0] RESET_PC  = '0,
  parameter logic [31:0]          NOP_INST  = 32'h00000013
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall_if,
  input  logic                 stall_id,
  input  logic                 flush_id,
  input  logic                 redirect_en,
  input  logic [DATA_SIZE-1:0] redirect_pc,
  output logic                 mem_rd_en,
  output logic [DATA_SIZE-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_rd_dat,
  output logic [31:0]          inst_id,
  output logic [DATA_SIZE-1:0] pc_id,
  output logic [DATA_SIZE-1:0] pc_plus_4_id,
  output logic                 valid_id
);

  typedef enum logic [1:0] {IDLE, REQ, DROP, HOLD} state_t;

  state_t               state, state_next;
  logic [DATA_SIZE-1:0] pc, pc_next, mem_addr_next;
  logic [DATA_SIZE-1:0] redirect_tgt, addr_plus_4;
  logic [31:0]          hold_inst, load_inst;
  logic [DATA_SIZE-1:0] hold_pc, load_pc;
  logic                 load, capture;

  assign redirect_tgt = redirect_pc & ~DATA_SIZE'(3);
  assign addr_plus_4  = mem_addr + DATA_SIZE'(4);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!stall_if) state_next = REQ;
      REQ: begin
        if (mem_ack && redirect_en) state_next = REQ;
        else if (mem_ack && !stall_id) state_next = stall_if ? IDLE : REQ;
        else if (mem_ack) state_next = HOLD;
        else if (redirect_en) state_next = DROP;
      end
      DROP: if (mem_ack) state_next = REQ;
      HOLD: begin
        if (redirect_en) state_next = IDLE;
        else if (!stall_id) state_next = stall_if ? IDLE : REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pc_next       = pc;
    mem_addr_next = mem_addr;
    load          = 1'b0;
    load_inst     = hold_inst;
    load_pc       = hold_pc;
    capture       = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_en) pc_next = redirect_tgt;
        if (!stall_if) mem_addr_next = redirect_en ? redirect_tgt : pc;
      end
      REQ: begin
        if (mem_ack && redirect_en) begin
          mem_addr_next = redirect_tgt;
          pc_next       = redirect_tgt;
        end else if (mem_ack) begin
          pc_next = addr_plus_4;
          if (!stall_id) begin
            load      = 1'b1;
            load_inst = mem_rd_dat;
            load_pc   = mem_addr;
            if (!stall_if) mem_addr_next = addr_plus_4;
          end else begin
            capture = 1'b1;
          end
        end else if (redirect_en) begin
          pc_next = redirect_tgt;
        end
      end
      DROP: begin
        // A redirect landing on the same cycle as the ack must win over the stale pc.
        if (redirect_en) pc_next = redirect_tgt;
        if (mem_ack) mem_addr_next = redirect_en ? redirect_tgt : pc;
      end
      HOLD: begin
        if (redirect_en) begin
          pc_next = redirect_tgt;
        end else if (!stall_id) begin
          load = 1'b1;
          if (!stall_if) mem_addr_next = pc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc        <= RESET_PC;
      mem_addr  <= RESET_PC;
      mem_rd_en <= 1'b0;
      hold_inst <= NOP_INST;
      hold_pc   <= '0;
    end else begin
      pc        <= pc_next;
      mem_addr  <= mem_addr_next;
      mem_rd_en <= (state_next == REQ) || (state_next == DROP);
      if (capture) begin
        hold_inst <= mem_rd_dat;
        hold_pc   <= mem_addr;
      end
    end
  end

  // IF/ID priority: reset > flush > stall > load; otherwise insert a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      inst_id      <= NOP_INST;
      pc_id        <= '0;
      pc_plus_4_id <= '0;
      valid_id     <= 1'b0;
    end else if (flush_id) begin
      inst_id  <= NOP_INST;
      valid_id <= 1'b0;
    end else if (stall_id) begin
      valid_id <= valid_id;
    end else if (load) begin
      inst_id      <= load_inst;
      pc_id        <= load_pc;
      pc_plus_4_id <= load_pc + DATA_SIZE'(4);
      valid_id     <= 1'b1;
    end else begin
      valid_id <= 1'b0;
    end
  end

endmodule
